// File: rtl/spi_slave_port.sv
// SPI slave endpoint, all four CPOL/CPHA modes, MSB/LSB first.
// SPI lines are oversampled in the clk_i domain; TX via a one-byte holding register.
module spi_slave_port #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sclk_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_en_o,
  input  logic       clock_pol_i,
  input  logic       clock_pha_i,
  input  logic       bit_order_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       underrun_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEL
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;

  logic [7:0] shift_q;
  logic [7:0] rx_sh_q;
  logic [7:0] rx_sh_nxt;
  logic [2:0] cnt_q;
  logic       reload_pend_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       underrun_q;

  logic       lead;
  logic       trail;
  logic       sample_e;
  logic       shift_e;
  logic       cs_fall;
  logic       cs_rise;
  logic       sel_active;
  logic       do_sample;
  logic       do_shift;
  logic       load_now;
  logic       hold_wr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead    = (sclk_d == clock_pol_i) && (sclk_s != clock_pol_i);
  assign trail   = (sclk_d != clock_pol_i) && (sclk_s == clock_pol_i);
  assign cs_fall = cs_d && !cs_s;
  assign cs_rise = !cs_d && cs_s;

  always_comb begin
    sample_e = 1'b0;
    shift_e  = 1'b0;
    unique case (1'b1)
      clock_pha_i: begin
        sample_e = trail;
        shift_e  = lead;
      end
      default: begin
        sample_e = lead;
        shift_e  = trail;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cs_fall) state_d = S_LOAD;
      S_LOAD: state_d = cs_rise ? S_IDLE : S_SEL;
      S_SEL:  if (cs_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A shift edge at count 0 with no pending reload is the first CPHA=1
  // leading edge: the first bit is already on miso from LOAD.
  assign sel_active = (state_q == S_SEL) && !cs_rise;
  assign do_sample  = sel_active && sample_e;
  assign do_shift   = sel_active && shift_e && !reload_pend_q
                      && (cnt_q != 3'd0);
  assign load_now   = (state_q == S_LOAD)
                      || (sel_active && shift_e && reload_pend_q);
  assign hold_wr    = tx_valid_i && !hold_full_q;

  assign rx_sh_nxt = bit_order_i ? {mosi_s, rx_sh_q[7:1]}
                                 : {rx_sh_q[6:0], mosi_s};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q       <= IDLE_FILL;
      rx_sh_q       <= 8'h00;
      cnt_q         <= 3'd0;
      reload_pend_q <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      if (load_now) begin
        shift_q       <= hold_full_q ? hold_q : IDLE_FILL;
        underrun_q    <= !hold_full_q;
        reload_pend_q <= 1'b0;
      end else if (do_shift) begin
        shift_q <= bit_order_i ? {1'b1, shift_q[7:1]}
                               : {shift_q[6:0], 1'b1};
      end
      if (state_q == S_LOAD) begin
        cnt_q <= 3'd0;
      end else if (state_q == S_SEL && cs_rise) begin
        cnt_q         <= 3'd0;
        reload_pend_q <= 1'b0;
      end else if (do_sample) begin
        rx_sh_q <= rx_sh_nxt;
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          rx_data_q     <= rx_sh_nxt;
          rx_valid_q    <= 1'b1;
          reload_pend_q <= 1'b1;
        end
      end
    end
  end

  // Writes only land while empty, so a same-cycle reload sees it empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      if (hold_wr) begin
        hold_q      <= tx_data_i;
        hold_full_q <= 1'b1;
      end else if (load_now) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign miso_o     = (state_q == S_SEL)
                      ? (bit_order_i ? shift_q[0] : shift_q[7])
                      : 1'b1;
  assign miso_en_o  = (state_q != S_IDLE);
  assign busy_o     = (state_q == S_SEL);
  assign tx_ready_o = !hold_full_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: bit-level SPI master model, vector table,
// corner sequences and randomized frames checked against byte queues.
module tb_spi_slave_port;

  localparam int SS = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       sclk_i;
  logic       cs_n_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_en_o;
  logic       clock_pol_i;
  logic       clock_pha_i;
  logic       bit_order_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       underrun_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  spi_slave_port #(
    .SYNC_STAGES(SS),
    .IDLE_FILL  (8'hFF)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sclk_i     (sclk_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_en_o  (miso_en_o),
    .clock_pol_i(clock_pol_i),
    .clock_pha_i(clock_pha_i),
    .bit_order_i(bit_order_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .underrun_o (underrun_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    bit         cpol;
    bit         cpha;
    bit         lsb;
    bit         pre;
    logic [7:0] mo;
    logic [7:0] sb;
    logic [7:0] exp_mi;
    logic [7:0] exp_rx;
    int         exp_ur;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         h = 8;
  bit         rst_abort = 0;
  logic [7:0] mo [4];
  logic [7:0] sb [4];
  logic [7:0] mi [4];
  logic [7:0] rx_q [$];
  int         ucnt = 0;
  vec_t       tbl [5];

  always @(negedge clk_i) begin
    if (rx_valid_o) rx_q.push_back(rx_data_o);
    if (underrun_o) ucnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic bitof(input logic [7:0] b, input int i);
    return bit_order_i ? b[i] : b[7-i];
  endfunction

  function automatic logic [12:0] outs();
    return {miso_o, miso_en_o, tx_ready_o, rx_data_o,
            rx_valid_o, underrun_o, busy_o};
  endfunction

  localparam logic [12:0] RST_OUTS = {1'b1, 1'b0, 1'b1, 8'h00,
                                      1'b0, 1'b0, 1'b0};

  task automatic half(input bit wr, input logic [7:0] d);
    for (int c = 1; c <= h; c++) begin
      @(posedge clk_i); #1;
      tx_valid_i = 1'b0;
      if (wr && c == 4) begin
        chk("ready_mid_frame", tx_ready_o, 1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
      end
    end
  endtask

  task automatic write_hold(input logic [7:0] d);
    int c;
    c = 0;
    while (!tx_ready_o && c < 50) begin
      @(posedge clk_i); #1;
      c++;
    end
    chk("ready_before_write", tx_ready_o, 1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    @(posedge clk_i); #1;
    tx_valid_i = 1'b0;
  endtask

  task automatic run_frame(input int nbytes, input int stop_bits,
                           input bit wr_next);
    int  nb;
    int  c;
    bit  stop;
    bit  wr;
    nb   = 0;
    stop = 0;
    sclk_i = clock_pol_i;
    if (!clock_pha_i) mosi_i = bitof(mo[0], 0);
    cs_n_i = 1'b0;
    for (int k = 0; k < nbytes && !stop; k++) begin
      for (int i = 0; i < 8 && !stop; i++) begin
        if (stop_bits > 0 && nb == stop_bits) begin
          stop = 1;
        end else begin
          wr = wr_next && i == 0 && (k + 1) < nbytes;
          if (!clock_pha_i) begin
            mosi_i = bitof(mo[k], i);
            half(0, 8'h00);
            sclk_i = ~clock_pol_i;
            mi[k][bit_order_i ? i : 7 - i] = miso_o;
            half(wr, sb[(k + 1) % 4]);
            sclk_i = clock_pol_i;
          end else begin
            half(0, 8'h00);
            sclk_i = ~clock_pol_i;
            mosi_i = bitof(mo[k], i);
            half(wr, sb[(k + 1) % 4]);
            sclk_i = clock_pol_i;
            mi[k][bit_order_i ? i : 7 - i] = miso_o;
          end
          nb++;
        end
      end
    end
    if (stop && rst_abort) begin
      rst_n_i = 1'b0;
      #2;
      chk("reset_mid_xfer", outs(), RST_OUTS);
      cs_n_i = 1'b1;
      sclk_i = clock_pol_i;
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
    end else if (stop) begin
      cs_n_i = 1'b1;
      c = 0;
      while (miso_en_o && c < SS + 2) begin
        @(posedge clk_i); #1;
        c++;
      end
      chk("abort_miso_en", miso_en_o, 0);
    end else begin
      half(0, 8'h00);
      cs_n_i = 1'b1;
    end
    sclk_i = clock_pol_i;
    half(0, 8'h00);
    half(0, 8'h00);
  endtask

  task automatic set_mode(input bit cpol, input bit cpha, input bit lsb);
    clock_pol_i = cpol;
    clock_pha_i = cpha;
    bit_order_i = lsb;
    sclk_i      = cpol;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int base;
    int ub;
    int nbytes;
    bit pre;
    logic [7:0] exp_b;

    rst_n_i     = 1'b0;
    sclk_i      = 1'b0;
    cs_n_i      = 1'b1;
    mosi_i      = 1'b0;
    clock_pol_i = 1'b0;
    clock_pha_i = 1'b0;
    bit_order_i = 1'b0;
    tx_data_i   = 8'h00;
    tx_valid_i  = 1'b0;

    tbl[0] = '{0, 0, 0, 1, 8'h3C, 8'hA5, 8'hA5, 8'h3C, 1};
    tbl[1] = '{0, 1, 1, 1, 8'h81, 8'h0F, 8'h0F, 8'h81, 0};
    tbl[2] = '{1, 0, 1, 1, 8'h81, 8'h0F, 8'h0F, 8'h81, 1};
    tbl[3] = '{1, 1, 1, 1, 8'h81, 8'h0F, 8'h0F, 8'h81, 0};
    tbl[4] = '{0, 1, 0, 0, 8'h5E, 8'h00, 8'hFF, 8'h5E, 1};

    repeat (4) @(posedge clk_i);
    #1;
    chk("reset_values", outs(), RST_OUTS);
    rst_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;

    for (int v = 0; v < 5; v++) begin
      set_mode(tbl[v].cpol, tbl[v].cpha, tbl[v].lsb);
      if (tbl[v].pre) begin
        write_hold(tbl[v].sb);
        chk("hold_full_after_write", tx_ready_o, 0);
      end
      base  = rx_q.size();
      ub    = ucnt;
      mo[0] = tbl[v].mo;
      run_frame(1, 0, 0);
      chk("vec_master_rx", mi[0], tbl[v].exp_mi);
      chk("vec_rx_pulses", rx_q.size() - base, 1);
      chk("vec_rx_data", rx_data_o, tbl[v].exp_rx);
      chk("vec_underruns", ucnt - ub, tbl[v].exp_ur);
      chk("vec_ready_after", tx_ready_o, 1);
    end

    // back-to-back bytes with cs_n held low
    set_mode(1, 1, 0);
    write_hold(8'h11);
    sb[1] = 8'h22;
    mo[0] = 8'hC6;
    mo[1] = 8'h39;
    base  = rx_q.size();
    ub    = ucnt;
    run_frame(2, 0, 1);
    chk("b2b_master_rx0", mi[0], 8'h11);
    chk("b2b_master_rx1", mi[1], 8'h22);
    chk("b2b_rx_pulses", rx_q.size() - base, 2);
    if (rx_q.size() - base == 2) begin
      chk("b2b_rx0", rx_q[base], 8'hC6);
      chk("b2b_rx1", rx_q[base + 1], 8'h39);
    end
    chk("b2b_underruns", ucnt - ub, 0);

    // cs_n released after 5 bits, then a full byte
    set_mode(0, 0, 0);
    write_hold(8'h77);
    mo[0] = 8'hB2;
    base  = rx_q.size();
    run_frame(1, 5, 0);
    chk("abort_no_rx", rx_q.size() - base, 0);
    chk("abort_not_busy", busy_o, 0);
    write_hold(8'h96);
    mo[0] = 8'hE7;
    base  = rx_q.size();
    run_frame(1, 0, 0);
    chk("after_abort_master_rx", mi[0], 8'h96);
    chk("after_abort_rx_pulses", rx_q.size() - base, 1);
    chk("after_abort_rx", rx_data_o, 8'hE7);

    // reset after 3 bits, then a clean transfer
    write_hold(8'h44);
    mo[0] = 8'h99;
    base  = rx_q.size();
    rst_abort = 1;
    run_frame(1, 3, 0);
    rst_abort = 0;
    chk("rst_no_rx", rx_q.size() - base, 0);
    chk("rst_after_release", outs(), RST_OUTS);
    write_hold(8'hC3);
    mo[0] = 8'h5A;
    base  = rx_q.size();
    run_frame(1, 0, 0);
    chk("rst_then_master_rx", mi[0], 8'hC3);
    chk("rst_then_rx", rx_data_o, 8'h5A);
    chk("rst_then_rx_pulses", rx_q.size() - base, 1);

    // randomized frames against byte-level expectations
    for (int f = 0; f < 20; f++) begin
      set_mode($urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 1));
      h      = $urandom_range(5, 10);
      nbytes = $urandom_range(1, 3);
      pre    = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        mo[k] = 8'($urandom);
        sb[k] = 8'($urandom);
      end
      if (pre) write_hold(sb[0]);
      base = rx_q.size();
      run_frame(nbytes, 0, 1);
      chk("rnd_rx_pulses", rx_q.size() - base, nbytes);
      for (int k = 0; k < nbytes; k++) begin
        exp_b = (k == 0 && !pre) ? 8'hFF : sb[k];
        chk("rnd_master_rx", mi[k], exp_b);
        if (base + k < rx_q.size())
          chk("rnd_slave_rx", rx_q[base + k], mo[k]);
      end
      chk("rnd_ready_after", tx_ready_o, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave endpoint that consumes the sclk/cs_n/mosi lines produced by the SPI master and returns miso.
- Used as an on-chip loopback target and device model for the SPI master, and as a slave interface for the SoC.
- All SPI inputs are oversampled in the system clock domain. Received bytes are delivered on a valid strobe; bytes to send are accepted through a valid/ready holding register.
- Supports all four CPOL/CPHA modes and MSB-first or LSB-first bit order.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer (sclk, cs_n, mosi); must be >= 2.
- IDLE_FILL, 8'hFF, byte shifted out when the TX holding register is empty at byte start.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- sclk_i  in  1  SPI clock from master
- cs_n_i  in  1  chip select, active low
- mosi_i  in  1  master-out data
- miso_o  out  1  slave-out data
- miso_en_o  out  1  miso drive enable (high while selected)
- clock_pol_i  in  1  CPOL, static while selected
- clock_pha_i  in  1  CPHA, static while selected
- bit_order_i  in  1  0 = MSB first, 1 = LSB first; static while selected
- tx_data_i  in  8  next byte to transmit
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  holding register empty; transfer occurs on tx_valid_i & tx_ready_o
- rx_data_o  out  8  last complete received byte
- rx_valid_o  out  1  one-cycle strobe, rx_data_o updated
- underrun_o  out  1  one-cycle strobe, IDLE_FILL used because holding register was empty
- busy_o  out  1  high while in SELECTED state

Behaviour:
- Reset values:
  - Synchronizer chains: sclk chain = 0, cs_n chain = 1, mosi chain = 0.
  - Outputs: miso_o = 1, miso_en_o = 0, tx_ready_o = 1, rx_data_o = 8'h00, rx_valid_o = 0, underrun_o = 0, busy_o = 0.
  - Internal: bit counter = 0, state = IDLE.
- Input path: SYNC_STAGES-deep synchronizers, then one more register on sclk for edge detection.
  - Input-to-action latency is SYNC_STAGES+1 clk cycles.
  - Master SCLK half-period must be >= SYNC_STAGES+2 clk cycles; no behaviour is guaranteed below this.
- Edge definitions:
  - Leading edge = synced sclk changes from CPOL to !CPOL.
  - Trailing edge = synced sclk changes from !CPOL back to CPOL.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- FSM states:
  - IDLE:
    - miso_en_o = 0, miso_o = 1, edges ignored.
    - Synced cs_n falling edge -> LOAD.
  - LOAD (exactly 1 cycle):
    - Shift register <= holding register if full (holding cleared, tx_ready_o = 1 next cycle), else IDLE_FILL with underrun_o pulsed.
    - bit counter <= 0, miso_en_o = 1, -> SELECTED.
  - SELECTED:
    - miso_o = shift register MSB (bit_order 0) or LSB (bit_order 1).
    - On sample edge: synced mosi enters the receive register at the LSB end (MSB first) or MSB end (LSB first); bit counter increments (3-bit, wraps 7->0).
    - On shift edge: TX shift register shifts by one in the selected order.
    - Sample that brings the counter 7->0: rx_data_o <= completed byte, rx_valid_o pulses the next cycle.
    - Next byte reload:
      - CPHA=0: reload occurs on the shift edge that follows the 8th sample, in place of shifting.
      - CPHA=1: reload occurs on the first shift edge of the next byte, in place of shifting.
      - The reload takes from the holding register, or uses IDLE_FILL and pulses underrun_o.
    - Synced cs_n rising edge -> IDLE from any bit position.
      - A partial byte is discarded: no rx_valid_o, counter cleared.
      - An unsent holding byte remains held.
- Holding register:
  - Writes are accepted in any state.
  - A write and a reload in the same cycle: the reload takes the old content (or IDLE_FILL if empty), and the new byte is stored; tx_ready_o stays 0.
- CPOL, CPHA or bit_order changes while busy_o = 1: undefined result, no lockup; the block recovers on the next cs_n deassert.
- Asynchronous reset mid-transfer returns everything to reset values immediately; rx_valid_o is not generated.

Test Plan:
- Mode 0, MSB first, holding = 8'hA5, master sends 8'h3C with half-period 8 clk -> miso sequence 1,0,1,0,0,1,0,1; rx_data_o = 8'h3C; one rx_valid_o pulse; tx_ready_o returns to 1 after LOAD.
- Modes 1/2/3 each with bit_order = 1, master sends 8'h81, holding = 8'h0F -> rx_data_o = 8'h81; master receives 8'h0F in all three modes.
- Two back-to-back bytes with cs_n held low, holding written with 8'h11 then 8'h22 during the first byte -> master receives 8'h11, 8'h22; two rx_valid_o pulses; no underrun_o.
- Empty holding register at LOAD -> master receives 8'hFF; underrun_o pulses exactly once.
- cs_n deasserted after 5 bits -> no rx_valid_o; miso_en_o = 0 within SYNC_STAGES+2 cycles; next full byte is received correctly starting from bit 0.
- rst_n_i asserted after 3 bits, then released -> all outputs at reset values; a subsequent 8'h5A transfer completes correctly.
